// File: rtl/blake2_msg_sched_if.sv
// rtl/blake2_msg_sched_if.sv - message-in / (x,y)-out handshake bundle for blake2_msg_sched
interface blake2_msg_sched_if #(
    parameter int W = 32
);
    logic         flush_i;
    logic         m_valid_i;
    logic         m_ready_o;
    logic [W-1:0] m_data_i;
    logic         xy_valid_o;
    logic         xy_ready_i;
    logic [W-1:0] x_o;
    logic [W-1:0] y_o;
    logic [3:0]   round_o;
    logic [2:0]   step_o;
    logic         last_o;

    modport master (
        output flush_i, m_valid_i, m_data_i, xy_ready_i,
        input  m_ready_o, xy_valid_o, x_o, y_o, round_o, step_o, last_o
    );

    modport slave (
        input  flush_i, m_valid_i, m_data_i, xy_ready_i,
        output m_ready_o, xy_valid_o, x_o, y_o, round_o, step_o, last_o
    );
endinterface

// File: rtl/blake2_msg_sched.sv
// rtl/blake2_msg_sched.sv - BLAKE2 message schedule: stores a 16-word block, emits SIGMA-permuted (x,y) pairs per G call
module blake2_msg_sched #(
    parameter int W = 32,
    parameter int R = 10
) (
    input  logic                clk,
    input  logic                rst,
    blake2_msg_sched_if.slave   bus
);
    typedef enum logic {ST_LOAD, ST_EMIT} state_e;

    localparam logic [3:0] R_LAST = 4'(R - 1);

    state_e       state_q, state_d;
    logic [3:0]   k_q, k_d;
    logic [3:0]   r_q, r_d;
    logic [3:0]   s_q, s_d;
    logic [2:0]   j_q, j_d;
    logic         m_ready_q, m_ready_d;
    logic         xy_valid_q, xy_valid_d;
    logic [W-1:0] mem_q [16];

    logic         m_fire;
    logic         xy_fire;
    logic [63:0]  row;
    logic [3:0]   x_idx;
    logic [3:0]   y_idx;

    // Entry 0 of each row sits in the most significant nibble.
    function automatic logic [63:0] sigma_row(input logic [3:0] s);
        case (s)
            4'd1:    sigma_row = 64'hEA489FD61C02B753;
            4'd2:    sigma_row = 64'hB8C052FDAE367194;
            4'd3:    sigma_row = 64'h7931DCBE265A40F8;
            4'd4:    sigma_row = 64'h905724AFE1BC683D;
            4'd5:    sigma_row = 64'h2C6A0B834D75FE19;
            4'd6:    sigma_row = 64'hC51FED4A0763928B;
            4'd7:    sigma_row = 64'hDB7EC13950F4862A;
            4'd8:    sigma_row = 64'h6FE9B308C2D714A5;
            4'd9:    sigma_row = 64'hA2847615FB9E3CD0;
            default: sigma_row = 64'h0123456789ABCDEF;
        endcase
    endfunction

    assign m_fire  = bus.m_valid_i && m_ready_q && !bus.flush_i && !rst;
    assign xy_fire = xy_valid_q && bus.xy_ready_i;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        r_d     = r_q;
        s_d     = s_q;
        j_d     = j_q;
        if (bus.flush_i) begin
            state_d = ST_LOAD;
            k_d     = 4'd0;
            r_d     = 4'd0;
            s_d     = 4'd0;
            j_d     = 3'd0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (m_fire) begin
                        k_d = k_q + 4'd1;
                        if (k_q == 4'd15) begin
                            state_d = ST_EMIT;
                            k_d     = 4'd0;
                            r_d     = 4'd0;
                            s_d     = 4'd0;
                            j_d     = 3'd0;
                        end
                    end
                end
                ST_EMIT: begin
                    if (xy_fire) begin
                        j_d = j_q + 3'd1;
                        if (j_q == 3'd7) begin
                            if (r_q == R_LAST) begin
                                state_d = ST_LOAD;
                                r_d     = 4'd0;
                                s_d     = 4'd0;
                            end else begin
                                r_d = r_q + 4'd1;
                                // s follows r mod 10 without a divider
                                s_d = (s_q == 4'd9) ? 4'd0 : s_q + 4'd1;
                            end
                        end
                    end
                end
                default: state_d = ST_LOAD;
            endcase
        end
        m_ready_d  = (state_d == ST_LOAD);
        xy_valid_d = (state_d == ST_EMIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_LOAD;
            k_q        <= 4'd0;
            r_q        <= 4'd0;
            s_q        <= 4'd0;
            j_q        <= 3'd0;
            m_ready_q  <= 1'b0;
            xy_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            r_q        <= r_d;
            s_q        <= s_d;
            j_q        <= j_d;
            m_ready_q  <= m_ready_d;
            xy_valid_q <= xy_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (m_fire) begin
            mem_q[k_q] <= bus.m_data_i;
        end
    end

    // Columns 2j and 2j+1 live at nibble offsets 15-2j and 14-2j from the bottom.
    assign row   = sigma_row(s_q);
    assign x_idx = row[{~j_q, 1'b1, 2'b00} +: 4];
    assign y_idx = row[{~j_q, 1'b0, 2'b00} +: 4];

    assign bus.m_ready_o  = m_ready_q;
    assign bus.xy_valid_o = xy_valid_q;
    assign bus.x_o        = mem_q[x_idx];
    assign bus.y_o        = mem_q[y_idx];
    assign bus.round_o    = r_q;
    assign bus.step_o     = j_q;
    assign bus.last_o     = xy_valid_q && (r_q == R_LAST) && (j_q == 3'd7);
endmodule

// File: tb/tb_blake2_msg_sched.sv
// tb/tb_blake2_msg_sched.sv - directed self-checking bench for blake2_msg_sched (W=32/R=10 and W=64/R=12)
module tb_blake2_msg_sched;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel64 = 1'b0;
    logic        m_valid = 1'b0;
    logic        flush = 1'b0;
    logic        xy_ready = 1'b0;
    logic [63:0] m_data = 64'd0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    blake2_msg_sched_if #(.W(32)) b32 ();
    blake2_msg_sched_if #(.W(64)) b64 ();

    assign b32.flush_i    = flush && !sel64;
    assign b32.m_valid_i  = m_valid && !sel64;
    assign b32.m_data_i   = m_data[31:0];
    assign b32.xy_ready_i = xy_ready && !sel64;
    assign b64.flush_i    = flush && sel64;
    assign b64.m_valid_i  = m_valid && sel64;
    assign b64.m_data_i   = m_data;
    assign b64.xy_ready_i = xy_ready && sel64;

    blake2_msg_sched #(.W(32), .R(10)) u32 (.clk(clk), .rst(rst), .bus(b32.slave));
    blake2_msg_sched #(.W(64), .R(12)) u64 (.clk(clk), .rst(rst), .bus(b64.slave));

    logic        o_mready, o_xyv, o_last;
    logic [63:0] o_x, o_y;
    logic [3:0]  o_round;
    logic [2:0]  o_step;
    assign o_mready = sel64 ? b64.m_ready_o  : b32.m_ready_o;
    assign o_xyv    = sel64 ? b64.xy_valid_o : b32.xy_valid_o;
    assign o_last   = sel64 ? b64.last_o     : b32.last_o;
    assign o_x      = sel64 ? b64.x_o        : {32'd0, b32.x_o};
    assign o_y      = sel64 ? b64.y_o        : {32'd0, b32.y_o};
    assign o_round  = sel64 ? b64.round_o    : b32.round_o;
    assign o_step   = sel64 ? b64.step_o     : b32.step_o;

    int sig [10][16] = '{
        '{ 0,  1,  2,  3,  4,  5,  6,  7,  8,  9, 10, 11, 12, 13, 14, 15},
        '{14, 10,  4,  8,  9, 15, 13,  6,  1, 12,  0,  2, 11,  7,  5,  3},
        '{11,  8, 12,  0,  5,  2, 15, 13, 10, 14,  3,  6,  7,  1,  9,  4},
        '{ 7,  9,  3,  1, 13, 12, 11, 14,  2,  6,  5, 10,  4,  0, 15,  8},
        '{ 9,  0,  5,  7,  2,  4, 10, 15, 14,  1, 11, 12,  6,  8,  3, 13},
        '{ 2, 12,  6, 10,  0, 11,  8,  3,  4, 13,  7,  5, 15, 14,  1,  9},
        '{12,  5,  1, 15, 14, 13,  4, 10,  0,  7,  6,  3,  9,  2,  8, 11},
        '{13, 11,  7, 14, 12,  1,  3,  9,  5,  0, 15,  4,  8,  6,  2, 10},
        '{ 6, 15, 14,  9, 11,  3,  0,  8, 12,  2, 13,  7,  1,  4, 10,  5},
        '{10,  2,  8,  4,  7,  6,  1,  5, 15, 11,  9, 14,  3, 12, 13,  0}
    };

    logic [63:0] px [128];
    logic [63:0] py [128];
    int          pr [128];
    int          pj [128];

    typedef struct {
        int          r;
        int          j;
        logic [63:0] x;
        logic [63:0] y;
    } vec_t;
    vec_t vt [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic load_block(input logic [63:0] base, input bit gaps);
        int k   = 0;
        int cyc = 0;
        bit idle = 1'b0;
        while (k < 16 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            xy_ready = 1'b0;
            if (idle) begin
                m_valid = 1'b0;
                idle    = 1'b0;
            end else begin
                m_valid = 1'b1;
                m_data  = base + 64'(k);
                if (o_mready) k++;
                idle = gaps;
            end
        end
        if (k < 16) chk("load_timeout", 64'(k), 64'd16);
    endtask

    task automatic collect(input int n, input logic [63:0] base, input int stall_at,
                           input int flush_at, input bit hold_mv);
        int got    = 0;
        int cyc    = 0;
        int stalls = 0;
        int r, j;
        while (got < n && cyc < n * 2 + 50) begin
            @(negedge clk);
            cyc++;
            m_valid = hold_mv;
            if (hold_mv) m_data = 64'hDEAD_BEEF_DEAD_BEEF;
            xy_ready = 1'b1;
            if (got == flush_at) begin
                flush = 1'b1;
                break;
            end
            if (got == stall_at && stalls < 5) begin
                xy_ready = 1'b0;
                stalls++;
                chk("stall_valid", 64'(o_xyv), 64'd1);
                chk("stall_x", o_x, base + 64'd6);
                chk("stall_y", o_y, base + 64'd7);
                chk("stall_step", 64'(o_step), 64'd3);
                continue;
            end
            if (!o_xyv) continue;
            r = got / 8;
            j = got % 8;
            chk($sformatf("x[%0d]", got), o_x, base + 64'(sig[r % 10][2 * j]));
            chk($sformatf("y[%0d]", got), o_y, base + 64'(sig[r % 10][2 * j + 1]));
            chk($sformatf("round[%0d]", got), 64'(o_round), 64'(r));
            chk($sformatf("step[%0d]", got), 64'(o_step), 64'(j));
            chk($sformatf("last[%0d]", got), 64'(o_last), 64'(got == n - 1));
            px[got] = o_x;
            py[got] = o_y;
            pr[got] = int'(o_round);
            pj[got] = int'(o_step);
            got++;
        end
        if (flush) begin
            @(negedge clk);
            flush    = 1'b0;
            xy_ready = 1'b0;
            chk("flush_xyv", 64'(o_xyv), 64'd0);
            chk("flush_mready", 64'(o_mready), 64'd1);
        end else begin
            chk("pair_count", 64'(got), 64'(n));
            @(negedge clk);
            m_valid  = 1'b0;
            xy_ready = 1'b0;
            chk("end_xyv", 64'(o_xyv), 64'd0);
            chk("end_mready", 64'(o_mready), 64'd1);
        end
    endtask

    initial begin
        vt[0] = '{0, 0, 64'd0,  64'd1};
        vt[1] = '{0, 7, 64'd14, 64'd15};
        vt[2] = '{1, 0, 64'd14, 64'd10};
        vt[3] = '{1, 1, 64'd4,  64'd8};
        vt[4] = '{2, 0, 64'd11, 64'd8};
        vt[5] = '{9, 0, 64'd10, 64'd2};
        vt[6] = '{9, 7, 64'd13, 64'd0};

        // reset held with m_valid high
        rst     = 1'b1;
        m_valid = 1'b1;
        m_data  = 64'hBAD;
        repeat (3) begin
            @(negedge clk);
            chk("rst_mready", 64'(o_mready), 64'd0);
            chk("rst_xyv", 64'(o_xyv), 64'd0);
        end
        rst     = 1'b0;
        m_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_mready", 64'(o_mready), 64'd1);
        chk("post_rst_xyv", 64'(o_xyv), 64'd0);

        // basic block plus table vectors
        load_block(64'd0, 1'b0);
        collect(80, 64'd0, -1, -1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("vec%0d_x", i), px[vt[i].r * 8 + vt[i].j], vt[i].x);
            chk($sformatf("vec%0d_y", i), py[vt[i].r * 8 + vt[i].j], vt[i].y);
            chk($sformatf("vec%0d_r", i), 64'(pr[vt[i].r * 8 + vt[i].j]), 64'(vt[i].r));
            chk($sformatf("vec%0d_j", i), 64'(pj[vt[i].r * 8 + vt[i].j]), 64'(vt[i].j));
        end

        // backpressure at r=0, j=3
        load_block(64'd0, 1'b0);
        collect(80, 64'd0, 3, -1, 1'b0);
        chk("bp_after_x", px[4], 64'd8);
        chk("bp_after_y", py[4], 64'd9);

        // W=64, R=12
        sel64 = 1'b1;
        load_block(64'hA000_0000_0000_0000, 1'b0);
        collect(96, 64'hA000_0000_0000_0000, -1, -1, 1'b0);
        chk("r10_x_lo", {32'd0, px[80][31:0]}, 64'd0);
        chk("r10_y_lo", {32'd0, py[80][31:0]}, 64'd1);
        chk("r11_x_lo", {32'd0, px[88][31:0]}, 64'd14);
        chk("r11_y_lo", {32'd0, py[88][31:0]}, 64'd10);
        sel64 = 1'b0;

        // flush at r=2, j=4 with xy_ready high, then reload
        load_block(64'd0, 1'b0);
        collect(80, 64'd0, -1, 20, 1'b0);
        load_block(64'd100, 1'b0);
        collect(80, 64'd100, -1, -1, 1'b0);
        chk("reload_first_x", px[0], 64'd100);
        chk("reload_first_y", py[0], 64'd101);

        // gapped load, m_valid held high through EMIT
        load_block(64'd0, 1'b1);
        collect(80, 64'd0, -1, -1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/blake2_msg_sched.md
Name: blake2_msg_sched

Overview:
- Message-schedule feeder for the BLAKE2 G mixing stage; the producer on the other side of G's x/y message-word inputs.
- Accepts one 16-word message block over a valid/ready stream and stores it.
- Emits the (x, y) word pair for every G invocation of every round, in order, permuted by the RFC 7693 SIGMA table.
- Sits between the padding/block-assembly logic and the round datapath that instantiates G.

Parameters:
- W, 32, message word width (32 for BLAKE2s, 64 for BLAKE2b).
- R, 10, rounds per compression (10 for BLAKE2s, 12 for BLAKE2b); legal range 1..15.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-high.
- flush_i  input  1  abort: discard the current block and return to LOAD.
- m_valid_i  input  1  message word valid.
- m_ready_o  output  1  block accepts a message word.
- m_data_i  input  W  message word; words arrive in order m[0]..m[15].
- xy_valid_o  output  1  x_o/y_o pair valid.
- xy_ready_i  input  1  round datapath consumes the pair.
- x_o  output  W  m[SIGMA[r mod 10][2j]].
- y_o  output  W  m[SIGMA[r mod 10][2j+1]].
- round_o  output  4  current round r.
- step_o  output  3  current G index j (0..7).
- last_o  output  1  high with the final pair of the block (r = R-1, j = 7).

Behaviour:
- Clocking and reset: one clock domain; reset is synchronous and active-high (rst on clk).
- Reset values: state LOAD, word counter 0, r = 0, j = 0, m_ready_o = 0, xy_valid_o = 0, last_o = 0. m_ready_o is registered and rises in the first cycle after rst deasserts. Message storage is not reset.
- Handshakes: a transfer occurs on a cycle with valid && ready. x_o, y_o, round_o, step_o and last_o hold stable while xy_valid_o && !xy_ready_i. xy_valid_o never drops without a transfer except on rst or flush_i.
- LOAD state:
  - m_ready_o = 1 and xy_valid_o = 0.
  - Each m transfer writes m[k] and increments k.
  - Gaps in m_valid_i are allowed.
  - The transfer with k = 15 moves the block to EMIT on the next cycle: m_ready_o = 0, xy_valid_o = 1, r = 0, j = 0, k = 0.
- EMIT state:
  - m_ready_o = 0; m_valid_i is ignored.
  - Each xy transfer advances j. On a transfer at j = 7, j wraps to 0 and r increments.
  - A SIGMA row index s tracks r mod 10 as a wrapping 0..9 counter; no divider is used.
  - The transfer at r = R-1, j = 7 returns the block to LOAD next cycle: xy_valid_o = 0, m_ready_o = 1, counters cleared.
  - Exactly 8*R pairs are emitted per block.
- Output datapath: x_o and y_o are muxed combinationally from registered storage and counters (SIGMA row s, columns 2j and 2j+1), with 0 latency relative to the counters. last_o = xy_valid_o && r == R-1 && j == 7.
- SIGMA table: the 10x16 table from RFC 7693, hard-coded. Row 0 is the identity. Row 1 is 14,10,4,8,9,15,13,6,1,12,0,2,11,7,5,3. Row 9 is 10,2,8,4,7,6,1,5,15,11,9,14,3,12,13,0.
- flush_i (either state): on the next cycle the block is in LOAD with k = r = j = s = 0, xy_valid_o = 0, m_ready_o = 1.
  - flush_i wins over a simultaneous m or xy transfer; that word or pair is discarded and the counters do not advance.
  - rst wins over flush_i.
- Reset mid-operation: the block returns to reset values with no partial output.
- Minimum block turnaround: 16 load cycles + 8*R emit cycles, with no idle bubble between phases.

Test Plan:
1. Reset: hold rst 3 cycles with m_valid_i = 1 -> m_ready_o = 0 and xy_valid_o = 0 during reset, no word captured; m_ready_o = 1 in the first cycle after release.
2. Basic block (W=32, R=10): load m[k] = k, xy_ready_i = 1 -> round 0 pairs (0,1),(2,3)..(14,15). Round 1 step 0 = (14,10), step 1 = (4,8). Round 9 step 0 = (10,2). Exactly 80 pairs, last_o only on the 80th; m_ready_o = 1 the following cycle.
3. Backpressure: drop xy_ready_i for 5 cycles at r = 0, j = 3 -> x_o = 6, y_o = 7, step_o = 3 and xy_valid_o = 1 held constant; the next accepted pair is (8,9), with none skipped or duplicated.
4. R=12, W=64, m[k] = 64'hA000_0000_0000_0000 + k -> round 10 step 0 returns row 0 (low words 0,1); round 11 step 0 returns (14,10); 96 pairs total.
5. Flush: assert flush_i at r = 2, j = 4 concurrent with xy_ready_i = 1 -> next cycle xy_valid_o = 0, m_ready_o = 1. Reload m[k] = 100+k; the first pair is (100,101).
6. Load gaps: m_valid_i toggled 1,0,1,0 during LOAD and held high during EMIT -> only 16 words stored, no EMIT-phase capture, pair sequence identical to scenario 2.
